// File: rtl/glyph_anchor_ctrl.sv
// glyph_anchor_ctrl: frame-synchronous anchor/enable sequencer (slide, blink, hold) for a glyph row
module glyph_anchor_ctrl #(
    parameter logic [9:0] X_POS       = 10'd224,
    parameter logic [9:0] Y_START     = 10'd0,
    parameter logic [9:0] Y_FINAL     = 10'd200,
    parameter logic [9:0] STEP        = 10'd4,
    parameter logic [5:0] BLINK_HALF  = 6'd15,
    parameter logic [3:0] BLINK_COUNT = 4'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       show,
    input  logic       hide,
    output logic [9:0] x0,
    output logic [9:0] y0,
    output logic       en,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;
    state_t      state, state_n;
    logic [9:0]  y0_n;
    logic        en_n;
    logic [5:0]  cnt, cnt_n, cnt_inc;
    logic [3:0]  blinks, blinks_n, blinks_inc;
    logic [10:0] sum;
    logic        show_p, hide_p, show_req, hide_req;

    assign x0         = X_POS;
    assign busy       = state != IDLE;
    assign show_req   = show_p | show;
    assign hide_req   = hide_p | hide;
    assign sum        = {1'b0, y0} + {1'b0, STEP};
    assign cnt_inc    = cnt + 6'd1;
    assign blinks_inc = blinks + 4'd1;

    // State, outputs, counters and sticky request flags; flags are consumed at every tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            y0     <= Y_START;
            en     <= 1'b0;
            cnt    <= '0;
            blinks <= '0;
            show_p <= 1'b0;
            hide_p <= 1'b0;
        end else begin
            state  <= state_n;
            y0     <= y0_n;
            en     <= en_n;
            cnt    <= cnt_n;
            blinks <= blinks_n;
            show_p <= frame_tick ? 1'b0 : show_req;
            hide_p <= frame_tick ? 1'b0 : hide_req;
        end
    end

    // Next-state evaluation, only acting on frame ticks so renderers never see mid-frame changes
    always_comb begin
        state_n  = state;
        y0_n     = y0;
        en_n     = en;
        cnt_n    = cnt;
        blinks_n = blinks;
        if (frame_tick) begin
            if (hide_req) begin
                state_n  = IDLE;
                y0_n     = Y_START;
                en_n     = 1'b0;
                cnt_n    = '0;
                blinks_n = '0;
            end else begin
                case (state)
                    IDLE: begin
                        y0_n    = Y_START;
                        en_n    = show_req;
                        state_n = show_req ? SLIDE : IDLE;
                    end
                    SLIDE: begin
                        en_n = 1'b1;
                        if (sum >= {1'b0, Y_FINAL}) begin
                            y0_n    = Y_FINAL;
                            state_n = (BLINK_COUNT == 4'd0) ? HOLD : BLINK;
                        end else begin
                            y0_n = sum[9:0];
                        end
                    end
                    BLINK: begin
                        if (cnt_inc == BLINK_HALF) begin
                            cnt_n = '0;
                            en_n  = ~en;
                            if (!en) begin
                                blinks_n = blinks_inc;
                                if (blinks_inc == BLINK_COUNT) begin
                                    state_n  = HOLD;
                                    blinks_n = '0;
                                end
                            end
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                    HOLD: begin
                        en_n = 1'b1;
                        y0_n = Y_FINAL;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_glyph_anchor_ctrl.sv
// tb_glyph_anchor_ctrl: directed checks of the glyph anchor sequencer
module tb_glyph_anchor_ctrl;
    logic       clk = 0, rst = 1, frame_tick = 0, show = 0, hide = 0;
    logic [9:0] x0, y0, x0_s, y0_s;
    logic       en, busy, en_s, busy_s;
    int         n_checks = 0, n_pass = 0;

    glyph_anchor_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .show(show), .hide(hide),
        .x0(x0), .y0(y0), .en(en), .busy(busy)
    );
    glyph_anchor_ctrl #(.Y_FINAL(10'd10)) dut_s (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .show(show), .hide(hide),
        .x0(x0_s), .y0(y0_s), .en(en_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk) frame_tick = 1;
        @(negedge clk) frame_tick = 0;
    endtask

    task automatic pulse_show();
        @(negedge clk) show = 1;
        @(negedge clk) show = 0;
    endtask

    task automatic pulse_hide();
        @(negedge clk) hide = 1;
        @(negedge clk) hide = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({x0, y0, en, busy} !== {10'd224, 10'd0, 1'b0, 1'b0})
            $display("FAIL reset_vals: x0=%0d y0=%0d en=%b busy=%b want 224 0 0 0", x0, y0, en, busy);
        else n_pass++;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({x0, y0, en, busy} !== {10'd224, 10'd0, 1'b0, 1'b0})
                $display("FAIL idle_tick%0d: x0=%0d y0=%0d en=%b busy=%b want 224 0 0 0", i, x0, y0, en, busy);
            else n_pass++;
        end
    endtask

    task automatic test_slide();
        logic [9:0] ys;
        pulse_show();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({en, busy} !== 2'b00) $display("FAIL show_waits_tick: en=%b busy=%b want 0 0", en, busy);
        else n_pass++;
        tick();
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b1, 1'b1})
            $display("FAIL slide_start: y0=%0d en=%b busy=%b want 0 1 1", y0, en, busy);
        else n_pass++;
        for (int k = 1; k <= 50; k++) begin
            tick();
            ys = (k * 4 > 10) ? 10'd10 : 10'(k * 4);
            n_checks++;
            if ({y0, en} !== {10'(k * 4), 1'b1})
                $display("FAIL slide_k%0d: y0=%0d en=%b want %0d 1", k, y0, en, k * 4);
            else n_pass++;
            if (k <= 4) begin
                n_checks++;
                if ({y0_s, en_s, busy_s} !== {ys, 1'b1, 1'b1})
                    $display("FAIL short_slide_k%0d: y0=%0d en=%b busy=%b want %0d 1 1", k, y0_s, en_s, busy_s, ys);
                else n_pass++;
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({y0, en} !== {10'd200, 1'b1}) $display("FAIL hold_between_ticks: y0=%0d en=%b want 200 1", y0, en);
        else n_pass++;
    endtask

    task automatic test_blink();
        for (int t = 1; t <= 90; t++) begin
            tick();
            n_checks++;
            if ({y0, en, busy} !== {10'd200, 1'((t / 15) % 2 == 0), 1'b1})
                $display("FAIL blink_t%0d: y0=%0d en=%b busy=%b want 200 %0d 1", t, y0, en, busy, (t / 15) % 2 == 0);
            else n_pass++;
        end
        for (int t = 0; t < 20; t++) begin
            tick();
            n_checks++;
            if ({y0, en, busy} !== {10'd200, 1'b1, 1'b1})
                $display("FAIL hold_t%0d: y0=%0d en=%b busy=%b want 200 1 1", t, y0, en, busy);
            else n_pass++;
        end
        n_checks++;
        if ({y0_s, en_s, busy_s} !== {10'd10, 1'b1, 1'b1})
            $display("FAIL short_hold: y0=%0d en=%b busy=%b want 10 1 1", y0_s, en_s, busy_s);
        else n_pass++;
    endtask

    task automatic test_hide_race();
        pulse_hide();
        tick();
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b0, 1'b0})
            $display("FAIL hide_from_hold: y0=%0d en=%b busy=%b want 0 0 0", y0, en, busy);
        else n_pass++;
        @(negedge clk) begin show = 1; hide = 1; end
        @(negedge clk) begin show = 0; hide = 0; end
        tick();
        n_checks++;
        if ({en, busy} !== 2'b00) $display("FAIL show_hide_same: en=%b busy=%b want 0 0", en, busy);
        else n_pass++;
        tick();
        n_checks++;
        if ({en, busy} !== 2'b00) $display("FAIL flags_cleared: en=%b busy=%b want 0 0", en, busy);
        else n_pass++;
        @(negedge clk) begin show = 1; frame_tick = 1; end
        @(negedge clk) begin show = 0; frame_tick = 0; end
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b1, 1'b1})
            $display("FAIL show_with_tick: y0=%0d en=%b busy=%b want 0 1 1", y0, en, busy);
        else n_pass++;
        tick();
        tick();
        pulse_show();
        tick();
        n_checks++;
        if (y0 !== 10'd12) $display("FAIL show_ignored_busy: y0=%0d want 12", y0);
        else n_pass++;
        repeat (7) tick();
        n_checks++;
        if (y0 !== 10'd40) $display("FAIL reach_40: y0=%0d want 40", y0);
        else n_pass++;
        pulse_hide();
        tick();
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b0, 1'b0})
            $display("FAIL hide_in_slide: y0=%0d en=%b busy=%b want 0 0 0", y0, en, busy);
        else n_pass++;
        pulse_show();
        tick();
        @(negedge clk) begin hide = 1; frame_tick = 1; end
        @(negedge clk) begin hide = 0; frame_tick = 0; end
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b0, 1'b0})
            $display("FAIL hide_with_tick: y0=%0d en=%b busy=%b want 0 0 0", y0, en, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_show();
        repeat (66) tick();
        n_checks++;
        if ({y0, en, busy} !== {10'd200, 1'b0, 1'b1})
            $display("FAIL blink_low_before_rst: y0=%0d en=%b busy=%b want 200 0 1", y0, en, busy);
        else n_pass++;
        pulse_show();
        @(negedge clk) rst = 1;
        #1;
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b0, 1'b0})
            $display("FAIL async_rst: y0=%0d en=%b busy=%b want 0 0 0", y0, en, busy);
        else n_pass++;
        @(negedge clk) rst = 0;
        repeat (3) tick();
        n_checks++;
        if ({y0, en, busy} !== {10'd0, 1'b0, 1'b0})
            $display("FAIL show_lost_on_rst: y0=%0d en=%b busy=%b want 0 0 0", y0, en, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_slide();
        test_blink();
        test_hide_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
